// File: rtl/fpmult_arbiter.sv
// Round-robin front end that shares one pipelined floating-point multiplier among
// NUM_REQ requesters, with a tag pipeline that routes each product back to its owner.
module fpmult_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWIDTH       = 16,
  parameter int MULT_LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_a,
  input  logic [NUM_REQ*DWIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DWIDTH-1:0]         mult_a,
  output logic [DWIDTH-1:0]         mult_b,
  output logic                      mult_issue,
  input  logic [DWIDTH-1:0]         mult_result,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_data,
  output logic                      busy
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]          rr_ptr;
  logic                    grant_vld_p0;
  logic [IDW-1:0]          grant_id_p0;
  logic [IDW-1:0]          issue_id_p1;
  logic [MULT_LATENCY-1:0] tag_vld_p2;
  logic [IDW-1:0]          tag_id_p2 [MULT_LATENCY];

  // First asserted request at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                           input logic [IDW-1:0] ptr);
    logic [IDW:0]   pick;
    logic [IDW-1:0] id;
    int             idx;
    pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      id = IDW'(idx);
      if (!pick[IDW] && vld[id]) pick = {1'b1, id};
    end
    return pick;
  endfunction

  assign {grant_vld_p0, grant_id_p0} = rr_pick(req_valid, rr_ptr);

  always_comb begin
    req_ready = '0;
    if (grant_vld_p0 && !rst) req_ready[grant_id_p0] = 1'b1;
  end

  assign busy = mult_issue | (|tag_vld_p2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      mult_issue  <= 1'b0;
      mult_a      <= '0;
      mult_b      <= '0;
      issue_id_p1 <= '0;
      tag_vld_p2  <= '0;
      for (int k = 0; k < MULT_LATENCY; k++) tag_id_p2[k] <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
    end else begin
      // p0 -> p1: handshake, operands registered toward the multiplier
      mult_issue <= grant_vld_p0;
      if (grant_vld_p0) begin
        mult_a      <= req_a[int'(grant_id_p0)*DWIDTH +: DWIDTH];
        mult_b      <= req_b[int'(grant_id_p0)*DWIDTH +: DWIDTH];
        issue_id_p1 <= grant_id_p0;
        rr_ptr      <= (grant_id_p0 == IDW'(NUM_REQ-1)) ? '0 : grant_id_p0 + 1'b1;
      end

      // p1 -> p2: tag travels alongside the multiplier's internal pipeline
      tag_vld_p2[0] <= mult_issue;
      tag_id_p2[0]  <= issue_id_p1;
      for (int k = 1; k < MULT_LATENCY; k++) begin
        tag_vld_p2[k] <= tag_vld_p2[k-1];
        tag_id_p2[k]  <= tag_id_p2[k-1];
      end

      // p2 -> response: head of the tag pipeline lines up with mult_result
      rsp_valid <= '0;
      if (tag_vld_p2[MULT_LATENCY-1]) begin
        rsp_valid <= NUM_REQ'(1) << tag_id_p2[MULT_LATENCY-1];
        rsp_data  <= mult_result;
      end
    end
  end
endmodule

// File: tb/tb_fpmult_arbiter.sv
// Directed bench for fpmult_arbiter: NUM_REQ=4, DWIDTH=16, MULT_LATENCY=4, with a
// behavioural multiplier whose "product" is an exponent-add approximation a+b-0x3C00.
module tb_fpmult_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;
  localparam int ML = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_a, req_b;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    mult_a, mult_b, mult_result, rsp_data;
  logic             mult_issue, busy;
  logic [NR-1:0]    rsp_valid;

  int n_chk  = 0;
  int n_pass = 0;

  fpmult_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .MULT_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mult_a(mult_a), .mult_b(mult_b), .mult_issue(mult_issue),
    .mult_result(mult_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return a + b - 16'h3C00;
  endfunction

  function automatic logic [DW-1:0] op_a(input int i);
    return 16'h3C00 + 16'(i) * 16'h0400;
  endfunction

  function automatic logic [DW-1:0] op_b(input int i);
    return 16'h4000 + 16'(i);
  endfunction

  // Multiplier model: result appears ML cycles after the issue cycle.
  logic [DW-1:0] mdl_pipe [ML];
  always @(posedge clk) begin
    mdl_pipe[0] <= mult_issue ? fmul(mult_a, mult_b) : 16'h0000;
    for (int k = 1; k < ML; k++) mdl_pipe[k] <= mdl_pipe[k-1];
  end
  assign mult_result = mdl_pipe[ML-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state, and no grant while reset is held
    #1 rst = 1'b1;
    #1;
    chk("rst_issue", {31'b0, mult_issue}, 0);
    chk("rst_mult_a", {16'b0, mult_a}, 0);
    chk("rst_mult_b", {16'b0, mult_b}, 0);
    chk("rst_rsp_valid", {28'b0, rsp_valid}, 0);
    chk("rst_rsp_data", {16'b0, rsp_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", {28'b0, req_ready}, 0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single request from requester 1
    @(negedge clk);
    req_a[1*DW +: DW] = 16'h3C00;
    req_b[1*DW +: DW] = 16'h4000;
    req_valid = 4'b0010;
    #1 chk("single_ready", {28'b0, req_ready}, 32'b0010);
    @(negedge clk);
    req_valid = '0;
    chk("single_issue", {31'b0, mult_issue}, 1);
    chk("single_mult_a", {16'b0, mult_a}, 32'h3C00);
    chk("single_mult_b", {16'b0, mult_b}, 32'h4000);
    chk("single_busy", {31'b0, busy}, 1);
    repeat (4) @(negedge clk);
    chk("single_rsp_early", {28'b0, rsp_valid}, 0);
    chk("single_busy_late", {31'b0, busy}, 1);
    @(negedge clk);
    chk("single_rsp_valid", {28'b0, rsp_valid}, 32'b0010);
    chk("single_rsp_data", {16'b0, rsp_data}, 32'h4000);
    chk("single_busy_done", {31'b0, busy}, 0);
    @(negedge clk);
    chk("single_rsp_pulse", {28'b0, rsp_valid}, 0);
    chk("single_rsp_hold", {16'b0, rsp_data}, 32'h4000);

    // Wrap-around: pointer sits at 2, requesters 0 and 1 pending
    @(negedge clk);
    req_a[0 +: DW] = 16'h3C00; req_b[0 +: DW] = 16'h3C00;
    req_a[DW +: DW] = 16'h4000; req_b[DW +: DW] = 16'h4400;
    req_valid = 4'b0011;
    #1 chk("wrap_ready0", {28'b0, req_ready}, 32'b0001);
    @(negedge clk);
    #1 chk("wrap_ready1", {28'b0, req_ready}, 32'b0010);
    chk("wrap_mult_a0", {16'b0, mult_a}, 32'h3C00);
    @(negedge clk);
    req_valid = '0;
    chk("wrap_mult_a1", {16'b0, mult_a}, 32'h4000);
    chk("wrap_mult_b1", {16'b0, mult_b}, 32'h4400);
    repeat (8) @(negedge clk);

    // Reset mid-flight: three issues, reset two cycles after the last handshake
    req_valid = 4'b0111;
    #1 chk("mid_ready0", {28'b0, req_ready}, 32'b0100);
    repeat (3) @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_issue", {31'b0, mult_issue}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("mid_no_rsp", {28'b0, rsp_valid}, 0);
      chk("mid_no_busy", {31'b0, busy}, 0);
    end
    req_valid = 4'b0110;
    #1 chk("post_rst_grant", {28'b0, req_ready}, 32'b0010);
    req_valid = '0;

    // All four requesting for 8 cycles, starting from a reset pointer
    for (int i = 0; i < NR; i++) begin
      req_a[i*DW +: DW] = op_a(i);
      req_b[i*DW +: DW] = op_b(i);
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      req_valid = (j < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("all_ready", {28'b0, req_ready}, (j < 8) ? (32'd1 << (j % 4)) : 32'd0);
      chk("all_issue", {31'b0, mult_issue}, (j >= 1 && j <= 8) ? 32'd1 : 32'd0);
      if (j >= 1 && j <= 8) chk("all_mult_a", {16'b0, mult_a}, {16'b0, op_a((j-1) % 4)});
      chk("all_rsp_valid", {28'b0, rsp_valid},
          (j >= 6 && j <= 13) ? (32'd1 << ((j-6) % 4)) : 32'd0);
      if (j >= 6 && j <= 13)
        chk("all_rsp_data", {16'b0, rsp_data}, {16'b0, fmul(op_a((j-6) % 4), op_b((j-6) % 4))});
    end

    // Back-to-back to requester 2 with fresh operands each cycle
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      if (j < 5) begin
        req_a[2*DW +: DW] = 16'h4400 + 16'(j);
        req_b[2*DW +: DW] = 16'h3800 + 16'(2*j);
        req_valid = 4'b0100;
      end else begin
        req_valid = '0;
      end
      #1;
      chk("b2b_ready", {28'b0, req_ready}, (j < 5) ? 32'b0100 : 32'd0);
      chk("b2b_rsp_valid", {28'b0, rsp_valid}, (j >= 6 && j <= 10) ? 32'b0100 : 32'd0);
      if (j >= 6 && j <= 10)
        chk("b2b_rsp_data", {16'b0, rsp_data},
            {16'b0, fmul(16'h4400 + 16'(j-6), 16'h3800 + 16'(2*(j-6)))});
    end

    // Idle: outputs quiet and data registers stable at the last values
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk("idle_issue", {31'b0, mult_issue}, 0);
      chk("idle_rsp_valid", {28'b0, rsp_valid}, 0);
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_mult_a", {16'b0, mult_a}, 32'h4404);
      chk("idle_mult_b", {16'b0, mult_b}, 32'h3808);
      chk("idle_rsp_data", {16'b0, rsp_data}, 32'h400C);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
